// File: rtl/ring_tune_pkg.sv
// ring_tune_pkg
//   Shared types and constants for the ring heater tuning controller.
//   - tune_state_t : controller state encoding
//   - HEATER_W_DEF / PD_W_DEF : default heater DAC and monitor ADC widths
//   - DIR_UP / DIR_DN : dither direction encoding used while tracking
package ring_tune_pkg;

    localparam int HEATER_W_DEF = 8;
    localparam int PD_W_DEF     = 10;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SWEEP_SET,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_LOCKED,
        ST_TRK_SET,
        ST_TRK_SETTLE,
        ST_TRK_SAMPLE,
        ST_FAIL
    } tune_state_t;

endpackage

// File: rtl/tune_dwell_timer.sv
// tune_dwell_timer
//   Loadable down-counter with a zero flag. Load has priority over
//   decrement; decrementing stops at zero.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset (count -> 0)
//     load/load_val : load the counter with load_val
//     dec           : decrement by one (saturates at zero)
//     zero          : count is zero
module tune_dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ring_heater_tune_ctrl.sv
// ring_heater_tune_ctrl
//   Thermal tuner sequencer for a resonant-ring modulator/receiver. Sweeps
//   the heater code over its full range, samples the drop-port monitor PD
//   at each code, locks to the strongest code, then periodically dithers
//   +1/-1 code to follow thermal drift.
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     enable         : level; dropping it aborts to IDLE with heater off
//     start          : pulse; begins an acquisition sweep (IDLE/LOCKED/FAIL)
//     pd_code/valid  : monitor photodetector ADC sample
//     heater_code    : heater DAC setting
//     heater_update  : one-cycle pulse each time heater_code is written
//     busy           : sweeping, evaluating or dithering
//     locked         : LOCKED or any tracking state
//     fail           : sticky; acquisition found no peak >= MIN_PD
//   heater_code/heater_update are registered: start sampled on edge N puts
//   the controller in SWEEP_SET, and the first pulse appears after edge N+1.
module ring_heater_tune_ctrl
    import ring_tune_pkg::*;
#(
    parameter int HEATER_W      = HEATER_W_DEF,
    parameter int PD_W          = PD_W_DEF,
    parameter int SETTLE_CYCLES = 16,
    parameter int MIN_PD        = 64,
    parameter int TRACK_PERIOD  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                start,
    input  logic [PD_W-1:0]     pd_code,
    input  logic                pd_valid,
    output logic [HEATER_W-1:0] heater_code,
    output logic                heater_update,
    output logic                busy,
    output logic                locked,
    output logic                fail
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TRK_W = $clog2(TRACK_PERIOD + 1);

    localparam logic [SET_W-1:0]    SETTLE_LD = SET_W'(SETTLE_CYCLES);
    localparam logic [TRK_W-1:0]    TRACK_LD  = TRK_W'(TRACK_PERIOD);
    localparam logic [PD_W-1:0]     MIN_PD_C  = PD_W'(MIN_PD);
    localparam logic [HEATER_W-1:0] MAX_CODE  = '1;

    tune_state_t         state, state_nxt;
    logic [HEATER_W-1:0] cur_code, cur_code_nxt;
    logic [HEATER_W-1:0] best_code, best_code_nxt;
    logic [PD_W-1:0]     best_pd, best_pd_nxt;
    logic                dir, dir_nxt;
    logic [HEATER_W-1:0] heater_q, heater_nxt;
    logic                upd_q, upd_nxt;
    logic                fail_q, fail_nxt;

    logic settle_load, settle_dec, settle_zero;
    logic track_load, track_dec, track_zero;
    logic start_ok;

    assign start_ok = start && enable;

    tune_dwell_timer #(.CNT_W(SET_W)) u_settle_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LD),
        .dec      (settle_dec),
        .zero     (settle_zero)
    );

    tune_dwell_timer #(.CNT_W(TRK_W)) u_track_tmr (
        .clk      (clk),
        .rst      (rst),
        .load     (track_load),
        .load_val (TRACK_LD),
        .dec      (track_dec),
        .zero     (track_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cur_code  <= '0;
            best_code <= '0;
            best_pd   <= '0;
            dir       <= DIR_UP;
            heater_q  <= '0;
            upd_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_code  <= cur_code_nxt;
            best_code <= best_code_nxt;
            best_pd   <= best_pd_nxt;
            dir       <= dir_nxt;
            heater_q  <= heater_nxt;
            upd_q     <= upd_nxt;
            fail_q    <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_code_nxt  = cur_code;
        best_code_nxt = best_code;
        best_pd_nxt   = best_pd;
        dir_nxt       = dir;
        heater_nxt    = heater_q;
        upd_nxt       = 1'b0;
        fail_nxt      = fail_q;
        settle_load   = 1'b0;
        settle_dec    = 1'b0;
        track_load    = 1'b0;
        track_dec     = 1'b0;

        if (!enable && (state != ST_IDLE)) begin
            // Abort: heater off; fail stays until a start or reset.
            state_nxt  = ST_IDLE;
            heater_nxt = '0;
            upd_nxt    = (heater_q != '0);
        end else begin
            case (state)
                ST_IDLE: begin
                    cur_code_nxt  = '0;
                    best_code_nxt = '0;
                    best_pd_nxt   = '0;
                    if (start_ok) begin
                        fail_nxt  = 1'b0;
                        state_nxt = ST_SWEEP_SET;
                    end
                end
                ST_SWEEP_SET: begin
                    heater_nxt  = cur_code;
                    upd_nxt     = 1'b1;
                    settle_load = 1'b1;
                    state_nxt   = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_zero) state_nxt = ST_SAMPLE;
                    else             settle_dec = 1'b1;
                end
                ST_SAMPLE: begin
                    if (pd_valid) begin
                        // Strict compare: on ties the earlier (lower) code wins.
                        if (pd_code > best_pd) begin
                            best_pd_nxt   = pd_code;
                            best_code_nxt = cur_code;
                        end
                        if (cur_code == MAX_CODE) begin
                            state_nxt = ST_EVAL;
                        end else begin
                            cur_code_nxt = cur_code + 1'b1;
                            state_nxt    = ST_SWEEP_SET;
                        end
                    end
                end
                ST_EVAL: begin
                    upd_nxt = 1'b1;
                    if (best_pd >= MIN_PD_C) begin
                        heater_nxt = best_code;
                        track_load = 1'b1;
                        state_nxt  = ST_LOCKED;
                    end else begin
                        heater_nxt = '0;
                        fail_nxt   = 1'b1;
                        state_nxt  = ST_FAIL;
                    end
                end
                ST_LOCKED: begin
                    if (start_ok) begin
                        cur_code_nxt  = '0;
                        best_code_nxt = '0;
                        best_pd_nxt   = '0;
                        state_nxt     = ST_SWEEP_SET;
                    end else if (track_zero) begin
                        dir_nxt   = DIR_UP;
                        state_nxt = ST_TRK_SET;
                    end else begin
                        track_dec = 1'b1;
                    end
                end
                ST_TRK_SET: begin
                    // Range checks precede the add/subtract so the probe never wraps.
                    if (dir == DIR_UP) begin
                        if (best_code == MAX_CODE) begin
                            dir_nxt = DIR_DN;
                        end else begin
                            heater_nxt  = best_code + 1'b1;
                            upd_nxt     = 1'b1;
                            settle_load = 1'b1;
                            state_nxt   = ST_TRK_SETTLE;
                        end
                    end else begin
                        if (best_code == '0) begin
                            // Heater may still sit on a rejected +1 probe.
                            heater_nxt = best_code;
                            upd_nxt    = (heater_q != best_code);
                            track_load = 1'b1;
                            state_nxt  = ST_LOCKED;
                        end else begin
                            heater_nxt  = best_code - 1'b1;
                            upd_nxt     = 1'b1;
                            settle_load = 1'b1;
                            state_nxt   = ST_TRK_SETTLE;
                        end
                    end
                end
                ST_TRK_SETTLE: begin
                    if (settle_zero) state_nxt = ST_TRK_SAMPLE;
                    else             settle_dec = 1'b1;
                end
                ST_TRK_SAMPLE: begin
                    // The probe code is whatever the heater currently holds.
                    if (pd_valid) begin
                        if (pd_code > best_pd) begin
                            best_code_nxt = heater_q;
                            best_pd_nxt   = pd_code;
                            track_load    = 1'b1;
                            state_nxt     = ST_LOCKED;
                        end else if (dir == DIR_UP) begin
                            dir_nxt   = DIR_DN;
                            state_nxt = ST_TRK_SET;
                        end else begin
                            heater_nxt = best_code;
                            upd_nxt    = 1'b1;
                            track_load = 1'b1;
                            state_nxt  = ST_LOCKED;
                        end
                    end
                end
                ST_FAIL: begin
                    if (start_ok) begin
                        fail_nxt      = 1'b0;
                        cur_code_nxt  = '0;
                        best_code_nxt = '0;
                        best_pd_nxt   = '0;
                        state_nxt     = ST_SWEEP_SET;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign heater_code   = heater_q;
    assign heater_update = upd_q;
    assign fail          = fail_q;
    assign busy          = !((state == ST_IDLE) || (state == ST_LOCKED) || (state == ST_FAIL));
    assign locked        = (state == ST_LOCKED) || (state == ST_TRK_SET) ||
                           (state == ST_TRK_SETTLE) || (state == ST_TRK_SAMPLE);

endmodule
